mix_column_seq: RTL and testbench
=================================

Name: mix_column_seq

Overview:
- Iterative MixColumns / InvMixColumns stage that sits directly downstream of the bit-permutation stage in the modified AES round.
- Accepts the 128-bit bit-permuted state over a valid/ready handshake and processes one 32-bit column per clock through a single GF(2^8) column engine.
- Presents the mixed 128-bit state on an output valid/ready handshake to the AddRoundKey stage.

Parameters:
- NCOL, 4, number of 32-bit columns per state; fixed by AES and not intended to be overridden.
- COL_W, 32, column width in bits.

Ports:
- clk  input  1  single clock; all flops rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream state on in_state is valid.
- in_ready  output  1  block can accept a state this cycle.
- in_state  input  128  bit-permuted state. Column c occupies bits [127-32c -: 32], so [127:96] is column 0. Within a column, the MSB byte is row 0.
- in_inv  input  1  sampled with in_state: 0 = MixColumns, 1 = InvMixColumns.
- out_valid  output  1  out_state holds a finished result.
- out_ready  input  1  downstream accepts out_state.
- out_state  output  128  mixed state, same column/byte layout as in_state.
- busy  output  1  high while columns are being processed.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; column counter = 0; mode flop = 0.
  - out_state = 0, out_valid = 0, busy = 0, in_ready = 0 while rst is asserted.
  - in_ready = 1 from the first cycle after rst deasserts.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture in_state into the working register and in_inv into the mode flop; clear the counter; go to BUSY.
- BUSY:
  - in_ready = 0; busy = 1.
  - Each cycle, column[cnt] passes through the column engine and the result is written into result slot cnt; cnt then increments.
  - When cnt == 3 is written, go to DONE and clear cnt to 0.
- DONE:
  - out_valid = 1; out_state = result register.
  - The result is held stable until out_valid & out_ready.
- Leaving DONE on handshake:
  - If in_valid is also high that cycle, the new state is captured and the FSM goes straight to BUSY (back-to-back).
  - Otherwise the FSM goes to IDLE.
  - in_ready in DONE = out_ready (combinational pass-through).
- Latency: accept at edge k → out_valid high after edge k+4 (4 cycles).
- Throughput: one state per 5 cycles with out_ready tied high and back-to-back input.
- Arithmetic, all in GF(2^8) with polynomial 0x11B:
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
  - Forward matrix rows: [2 3 1 1] rotated.
  - Inverse matrix rows: [E B D 9] rotated, built from xtime chains; no lookup tables.
  - All column-engine logic is combinational, with no carries beyond 8 bits.
- Boundary and ordering rules:
  - in_state and in_inv are ignored outside a handshake.
  - Changes on in_state during BUSY have no effect.
  - out_state is not updated while out_valid is high and out_ready is low (backpressure).
  - rst asserted mid-BUSY or in DONE discards the work in progress; outputs return to reset values immediately.
  - The mode is latched per state, so in_inv toggling mid-operation is ignored.

Decomposition:
- Package aes_gf_pkg holds:
  - the xtime function and a gmul_const function (multiply by 2, 3, 9, B, D, E);
  - the FSM state enum {IDLE, BUSY, DONE};
  - the constants NCOL = 4, COL_W = 32 and AES_POLY = 8'h1B.
- One sub-module: mix_col_word. It is purely combinational with ports col_in[31:0], inv, col_out[31:0], and is instantiated once inside mix_column_seq.

Test Plan:
- Forward vector: in_inv=0, in_state=db135345_f20a225c_01010101_c6c6c6c6 → out_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid exactly 4 cycles after the accept edge.
- Inverse vector: in_inv=1, in_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6 → out_state=db135345_f20a225c_01010101_c6c6c6c6.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Required: out_state stable, in_ready=0, and a new in_valid is not accepted.
  - Then raise out_ready together with in_valid: the handshake completes and the FSM goes directly to BUSY.
- Back-to-back: three states with out_ready=1 and in_valid=1 throughout → three correct results, accepts 5 cycles apart, no state dropped or duplicated.
- Reset mid-operation: assert rst 2 cycles after an accept.
  - Required: out_valid=0, out_state=0 and busy=0 immediately.
  - After release: in_ready=1, and the next vector gives the correct result.
- Round trip: random states, forward then inverse (inv=1 on the second pass) → equal to the original input; in_state changes during BUSY do not alter the result.

Source files
------------

// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers and shared constants for the iterative MixColumns stage.
//   xtime      : multiply by x modulo the AES polynomial
//   gmul_const : multiply by one of the MixColumns coefficients {2,3,9,B,D,E}
//   state_t    : sequencer states for mix_column_seq
package aes_gf_pkg;

    localparam int         NCOL     = 4;
    localparam int         COL_W    = 32;
    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Coefficients are built from the x2/x4/x8 chain so no table is needed.
    function automatic logic [7:0] gmul_const(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (k)
            4'h2:    gmul_const = x2;
            4'h3:    gmul_const = x2 ^ b;
            4'h9:    gmul_const = x8 ^ b;
            4'hB:    gmul_const = x8 ^ x2 ^ b;
            4'hD:    gmul_const = x8 ^ x4 ^ b;
            4'hE:    gmul_const = x8 ^ x4 ^ x2;
            default: gmul_const = b;
        endcase
    endfunction

endpackage

// File: rtl/mix_column_seq_if.sv
// Handshake bundle for mix_column_seq.
//   in_valid/in_ready/in_state/in_inv : upstream state + mode
//   out_valid/out_ready/out_state     : mixed state to AddRoundKey
//   busy                              : columns in flight
// slave = the mixing block, master = the driver of in_* / out_ready.
interface mix_column_seq_if;
    import aes_gf_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [NCOL*COL_W-1:0]   in_state;
    logic                    in_inv;
    logic                    out_valid;
    logic                    out_ready;
    logic [NCOL*COL_W-1:0]   out_state;
    logic                    busy;

    modport slave (
        input  in_valid, in_state, in_inv, out_ready,
        output in_ready, out_valid, out_state, busy
    );

    modport master (
        output in_valid, in_state, in_inv, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

endinterface

// File: rtl/mix_col_word.sv
// Combinational single-column MixColumns / InvMixColumns engine.
//   col_in  : 32-bit column, MSB byte is row 0
//   inv     : 0 = forward [2 3 1 1], 1 = inverse [E B D 9]
//   col_out : mixed column, same byte order
module mix_col_word
    import aes_gf_pkg::*;
(
    input  logic [COL_W-1:0] col_in,
    input  logic             inv,
    output logic [COL_W-1:0] col_out
);

    // a[3] holds row 0, so row r lives at a[3-r].
    logic [3:0][7:0] a, y;

    assign a = col_in;

    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam int R0 = 3 - r;
        localparam int R1 = 3 - ((r + 1) % 4);
        localparam int R2 = 3 - ((r + 2) % 4);
        localparam int R3 = 3 - ((r + 3) % 4);

        logic [7:0] fwd, bwd;

        assign fwd = gmul_const(a[R0], 4'h2) ^ gmul_const(a[R1], 4'h3) ^ a[R2] ^ a[R3];
        assign bwd = gmul_const(a[R0], 4'hE) ^ gmul_const(a[R1], 4'hB)
                   ^ gmul_const(a[R2], 4'hD) ^ gmul_const(a[R3], 4'h9);
        assign y[R0] = inv ? bwd : fwd;
    end

    assign col_out = y;

endmodule

// File: rtl/mix_column_seq.sv
// Iterative MixColumns / InvMixColumns: accepts a 128-bit state, mixes one
// column per clock through a single mix_col_word, then presents the result.
//   clk, rst : clock, async active-high reset
//   bus      : mix_column_seq_if.slave (in/out handshakes, busy)
// Accept at edge k gives out_valid after edge k+4; back-to-back rate is one
// state every 5 cycles.
module mix_column_seq
    import aes_gf_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mix_column_seq_if.slave bus
);

    localparam int               CNT_W = $clog2(NCOL);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NCOL - 1);

    state_t                     state;
    logic [CNT_W-1:0]           cnt;
    logic                       mode;
    logic [NCOL-1:0][COL_W-1:0] work;
    logic [NCOL-1:0][COL_W-1:0] result;
    logic [COL_W-1:0]           col_cur;
    logic [COL_W-1:0]           col_mix;
    logic                       out_valid_q;
    logic                       busy_q;
    logic                       accept;

    // Column 0 sits in the top word, so column cnt is packed index LAST-cnt.
    assign col_cur = work[LAST - cnt];

    mix_col_word u_col (
        .col_in  (col_cur),
        .inv     (mode),
        .col_out (col_mix)
    );

    // In DONE the slot frees up in the same cycle the result leaves, so
    // in_ready follows out_ready there to allow back-to-back accepts.
    assign bus.in_ready  = !rst && ((state == IDLE) || (state == DONE && bus.out_ready));
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = result;
    assign bus.busy      = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            mode        <= 1'b0;
            work        <= '0;
            result      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        work   <= bus.in_state;
                        mode   <= bus.in_inv;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    result[LAST - cnt] <= col_mix;
                    if (cnt == LAST) begin
                        cnt         <= '0;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (accept) begin
                            work   <= bus.in_state;
                            mode   <= bus.in_inv;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            state  <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_column_seq.sv
module tb_mix_column_seq;

    localparam logic [127:0] V0 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] E0 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2 = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
    localparam logic [127:0] E2 = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mix_column_seq_if bus ();

    mix_column_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [127:0] sb[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Generic shift-and-add GF(2^8) multiply for the reference model.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model_fwd(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   b[4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) b[r] = s[127-32*c-8*r -: 8];
            for (int r = 0; r < 4; r++)
                o[127-32*c-8*r -: 8] = gm(b[r], 8'h02) ^ gm(b[(r+1)%4], 8'h03)
                                     ^ b[(r+2)%4] ^ b[(r+3)%4];
        end
        return o;
    endfunction

    // Present a state and wait (bounded) for it to be accepted; the expected
    // result is queued at the cycle the handshake happens.
    task automatic send(input logic [127:0] s, input logic inv, input logic [127:0] exp);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_state = s;
        bus.in_inv   = inv;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(exp);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept expected in_ready");
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && !bus.out_valid; i++) tick(1);
        if (!bus.out_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL out_valid_timeout: got 0 expected 1");
        end
    endtask

    initial begin
        time t_prev;
        logic [127:0] r, got;

        bus.in_valid  = 1'b0;
        bus.in_state  = '0;
        bus.in_inv    = 1'b0;
        bus.out_ready = 1'b0;

        fork
            begin : monitor
                logic [127:0] e;
                forever begin
                    @(negedge clk);
                    if (bus.out_valid && bus.out_ready) begin
                        if (sb.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL sb_unexpected: got %h expected no output", bus.out_state);
                        end else begin
                            e = sb.pop_front();
                            chk("sb_out", bus.out_state, e);
                        end
                    end
                end
            end
        join_none

        // Reset state
        tick(3);
        chk("rst_in_ready",  128'(bus.in_ready),  128'(0));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_busy",      128'(bus.busy),      128'(0));
        chk("rst_out_state", bus.out_state,       128'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 128'(bus.in_ready), 128'(1));

        // Forward vector with latency check
        bus.out_ready = 1'b1;
        send(V0, 1'b0, E0);
        chk("fwd_busy", 128'(bus.busy), 128'(1));
        tick(3);
        chk("lat_k3_out_valid", 128'(bus.out_valid), 128'(0));
        tick(1);
        chk("lat_k4_out_valid", 128'(bus.out_valid), 128'(1));
        tick(2);

        // Inverse vector
        send(E0, 1'b1, V0);
        wait_done();
        tick(2);

        // Backpressure with a competing in_valid
        bus.out_ready = 1'b0;
        send(V0, 1'b0, E0);
        wait_done();
        bus.in_valid = 1'b1;
        bus.in_state = E0;
        bus.in_inv   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("bp_out_state", bus.out_state,       E0);
            chk("bp_in_ready",  128'(bus.in_ready),  128'(0));
            chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
        end
        bus.out_ready = 1'b1;
        sb.push_back(V0);
        tick(1);
        bus.in_valid = 1'b0;
        chk("bp_direct_busy",      128'(bus.busy),      128'(1));
        chk("bp_direct_out_valid", 128'(bus.out_valid), 128'(0));
        wait_done();
        tick(2);

        // Back-to-back: three states, accepts exactly 5 cycles apart
        send(V0, 1'b0, E0);
        t_prev = $time;
        send(E2, 1'b1, V2);
        chk("b2b_gap1", 128'($time - t_prev), 128'(50));
        t_prev = $time;
        send(V2, 1'b0, E2);
        chk("b2b_gap2", 128'($time - t_prev), 128'(50));
        wait_done();
        tick(2);

        // Reset two cycles after an accept
        send(V0, 1'b0, E0);
        tick(2);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("mid_rst_out_state", bus.out_state,       128'(0));
        chk("mid_rst_busy",      128'(bus.busy),      128'(0));
        chk("mid_rst_in_ready",  128'(bus.in_ready),  128'(0));
        sb.delete();
        tick(1);
        rst = 1'b0;
        #1;
        chk("rel_rst_in_ready", 128'(bus.in_ready), 128'(1));
        send(V2, 1'b0, E2);
        wait_done();
        tick(2);

        // Round trip with input noise during BUSY
        for (int k = 0; k < 2; k++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            send(r, 1'b0, model_fwd(r));
            wait_done();
            got = bus.out_state;
            tick(1);
            send(got, 1'b1, r);
            for (int j = 0; j < 3; j++) begin
                bus.in_state = {$urandom, $urandom, $urandom, $urandom};
                bus.in_inv   = ~bus.in_inv;
                tick(1);
            end
            wait_done();
            tick(2);
        end

        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
